// File: rtl/up2_mem_pkg.sv
// Shared definitions for the up2 memory-port controller.
//   cmd_e     : command encodings carried on i_cmd
//   state_e   : controller FSM states
//   nib_width : converts a nibble count into a bit width
package up2_mem_pkg;

  typedef enum logic [1:0] {
    CMD_READ  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_SWAP  = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_WR     = 3'd2,
    ST_SWP_RD = 3'd3,
    ST_SWP_WR = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  function automatic int nib_width(input int nibbles);
    return 4 * nibbles;
  endfunction

endpackage

// File: rtl/up2_mem_shift.sv
// Nibble-serial address/data shift register.
//   clk, rst      : clock, synchronous active-high reset
//   shift_en      : shift shift_nib in at the top, everything moves down a nibble
//   shift_nib     : nibble to shift in
//   load_en       : parallel-load load_data into the data field
//   load_data     : data field load value
//   inc_en        : increment the address field (wraps), data field untouched
//   addr, data    : address field (upper bits) and data field (lower bits)
//   shift_out     : lowest nibble
// Only one of shift_en/load_en/inc_en is ever asserted by the controller;
// the priority below just keeps the logic well defined.
module up2_mem_shift
  import up2_mem_pkg::*;
#(
  parameter int ADDR_NIBBLES = 1,
  parameter int DATA_NIBBLES = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                shift_en,
  input  logic [3:0]                          shift_nib,
  input  logic                                load_en,
  input  logic [nib_width(DATA_NIBBLES)-1:0]  load_data,
  input  logic                                inc_en,
  output logic [nib_width(ADDR_NIBBLES)-1:0]  addr,
  output logic [nib_width(DATA_NIBBLES)-1:0]  data,
  output logic [3:0]                          shift_out
);

  localparam int AW = nib_width(ADDR_NIBBLES);
  localparam int DW = nib_width(DATA_NIBBLES);
  localparam int SW = AW + DW;

  logic [SW-1:0] sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh <= '0;
    end else if (shift_en) begin
      sh <= {shift_nib, sh[SW-1:4]};
    end else if (load_en) begin
      sh[DW-1:0] <= load_data;
    end else if (inc_en) begin
      sh[SW-1:DW] <= sh[SW-1:DW] + AW'(1);
    end
  end

  assign addr      = sh[SW-1:DW];
  assign data      = sh[DW-1:0];
  assign shift_out = sh[3:0];

endmodule

// File: rtl/up2_mem_ctrl.sv
// up2 memory-port controller: executes READ / WRITE / SWAP against a
// req/ack memory port using the address/data held in up2_mem_shift.
//   clk, rst                 : clock, synchronous active-high reset
//   o_read_req / i_read_ack  : read handshake, i_data valid with the ack
//   o_write_req / i_write_ack: write handshake, o_addr/o_data carry the write
//   o_addr, o_data           : address and data fields of the shift register
//   i_shift, i_shift_data    : nibble shift-in (IDLE only, no command pending)
//   o_shift_data             : lowest nibble of the shift register
//   i_cmd_valid, i_cmd, i_inc: command strobe, opcode, post-increment request
//   o_cmd_ack                : one-cycle completion pulse
//   o_busy                   : controller not idle
// Requests and status are decoded purely from the state register, so there
// is no combinational path from the acks to the requests.
module up2_mem_ctrl
  import up2_mem_pkg::*;
#(
  parameter int ADDR_NIBBLES = 1,
  parameter int DATA_NIBBLES = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                o_read_req,
  input  logic                                i_read_ack,
  output logic                                o_write_req,
  input  logic                                i_write_ack,
  output logic [nib_width(ADDR_NIBBLES)-1:0]  o_addr,
  output logic [nib_width(DATA_NIBBLES)-1:0]  o_data,
  input  logic [nib_width(DATA_NIBBLES)-1:0]  i_data,
  input  logic                                i_shift,
  input  logic [3:0]                          i_shift_data,
  output logic [3:0]                          o_shift_data,
  input  logic                                i_cmd_valid,
  input  logic [1:0]                          i_cmd,
  input  logic                                i_inc,
  output logic                                o_cmd_ack,
  output logic                                o_busy
);

  localparam int DW = nib_width(DATA_NIBBLES);

  state_e          state, state_nxt;
  logic            inc_q;
  logic [DW-1:0]   temp;
  logic            shift_en, load_en, inc_en;
  logic [DW-1:0]   load_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      inc_q <= 1'b0;
      temp  <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && i_cmd_valid) inc_q <= i_inc;
      // Hold the read half of a swap until the old data has been written.
      if (state == ST_SWP_RD && i_read_ack) temp <= i_data;
    end
  end

  always_comb begin
    state_nxt   = state;
    shift_en    = 1'b0;
    load_en     = 1'b0;
    load_data   = i_data;
    inc_en      = 1'b0;
    o_read_req  = 1'b0;
    o_write_req = 1'b0;
    o_cmd_ack   = 1'b0;
    o_busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          case (cmd_e'(i_cmd))
            CMD_READ:  state_nxt = ST_RD;
            CMD_WRITE: state_nxt = ST_WR;
            CMD_SWAP:  state_nxt = ST_SWP_RD;
            default:   state_nxt = ST_DONE;
          endcase
        end else begin
          shift_en = i_shift;
        end
      end
      ST_RD: begin
        o_read_req = 1'b1;
        if (i_read_ack) begin
          load_en   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_WR: begin
        o_write_req = 1'b1;
        if (i_write_ack) state_nxt = ST_DONE;
      end
      ST_SWP_RD: begin
        o_read_req = 1'b1;
        if (i_read_ack) state_nxt = ST_SWP_WR;
      end
      ST_SWP_WR: begin
        o_write_req = 1'b1;
        if (i_write_ack) begin
          load_en   = 1'b1;
          load_data = temp;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        o_cmd_ack = 1'b1;
        inc_en    = inc_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  up2_mem_shift #(
    .ADDR_NIBBLES(ADDR_NIBBLES),
    .DATA_NIBBLES(DATA_NIBBLES)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .shift_nib (i_shift_data),
    .load_en   (load_en),
    .load_data (load_data),
    .inc_en    (inc_en),
    .addr      (o_addr),
    .data      (o_data),
    .shift_out (o_shift_data)
  );

endmodule
